alarm_output_arbiter: RTL and testbench
=======================================

# alarm_output_arbiter

Shares the 7-segment display path (the `fsm` digit multiplexer) and the speaker between the clock, stopwatch and radio sources. It also schedules the alarm: detects an alarm match, rings with priority over every mode, and handles stop, snooze and auto-timeout. It sits in `top` between the source blocks (EnterTime, stopwatch, radio_interface) and the `fsm` / speaker pins, replacing the combinational `modeSelect` mux.

## Interface
- `RING_SECS`, 60, number of `sec_tick` pulses an unattended alarm rings before auto-stop (1..1023)
- `SNOOZE_SECS`, 300, number of `sec_tick` pulses spent in snooze before re-ringing (1..1023)

- `clk`  in  1  system clock
- `reset`  in  1  synchronous, active-high; one clock, reset is synchronous and active-high
- `sec_tick`  in  1  one-`clk` pulse per second
- `modeSelect`  in  2  0 clock, 1 stopwatch, 2 radio, 3 treated as 0
- `clock_digits`  in  24  BCD hh:mm:ss, [23:20] hrs tens … [3:0] sec ones
- `sw_digits`  in  24  BCD stopwatch digits, same packing
- `alarm_time`  in  16  BCD hh:mm, same packing as `clock_digits[23:8]`
- `alarm_en`  in  1  alarm armed
- `btn_stop`  in  1  debounced one-cycle pulse
- `btn_snooze`  in  1  debounced one-cycle pulse
- `radio_audio`  in  1  radio square wave
- `alarm_tone`  in  1  alarm square wave
- `choice`  out  24  digits to `fsm`
- `blank`  out  1  1 = `fsm` drives all anodes off
- `speaker`  out  1  audio to pin
- `sndOn`  out  1  amplifier enable
- `ringing`  out  1  state is RING
- `snoozing`  out  1  state is SNOOZE

## Operation
- Match: `match_now = alarm_en && clock_digits[23:8]==alarm_time && clock_digits[7:0]==8'h00`.
- `match_q` registers `match_now` and resets to 1, so no spurious ring occurs out of reset.
- Trigger is `match_now && !match_q`, i.e. the rising edge of the match.
- States:
  - IDLE: trigger -> RING, with `ring_cnt`=0 and `blink`=0.
  - RING:
    - `btn_stop` -> IDLE.
    - Else `btn_snooze` -> SNOOZE, with `snz_cnt`=0.
    - Else `!alarm_en` -> IDLE.
    - Else on `sec_tick`: if `ring_cnt==RING_SECS-1` -> IDLE; otherwise `ring_cnt`++ and `blink` toggles.
  - SNOOZE:
    - `btn_stop` or `!alarm_en` -> IDLE.
    - Else on `sec_tick`: if `snz_cnt==SNOOZE_SECS-1` -> RING, with `ring_cnt`=0 and `blink`=0; otherwise `snz_cnt`++.
    - Triggers in SNOOZE are ignored.
- Priority in RING: stop > snooze > disable > timeout. Snooze in the same cycle as the timeout tick enters SNOOZE.
- Buttons are ignored in IDLE. `btn_snooze` is ignored in SNOOZE.
- Counters are 10 bits and saturate-free; they never exceed the parameter minus 1.
- Output selection, registered from the current state:
  - RING: `choice`=`clock_digits`, `blank`=`blink`, `speaker`=`alarm_tone`, `sndOn`=1. This applies regardless of `modeSelect`.
  - IDLE/SNOOZE, mode 0/3: `choice`=`clock_digits`, `blank`=0, `speaker`=0, `sndOn`=0.
  - IDLE/SNOOZE, mode 1: `choice`=`sw_digits`, `blank`=0, `speaker`=0, `sndOn`=0.
  - IDLE/SNOOZE, mode 2: `choice`=`clock_digits`, `blank`=0, `speaker`=`radio_audio`, `sndOn`=1.
- `ringing` and `snoozing` are registered decodes of the state.

## Timing
- Reset, synchronous: state IDLE; `ring_cnt`=`snz_cnt`=0; `blink`=0; `match_q`=1.
- Output reset values: `choice`=24'h0, `blank`=0, `speaker`=0, `sndOn`=0, `ringing`=0, `snoozing`=0.
- Reset asserted mid-RING or mid-SNOOZE silences the speaker at the first edge with `reset`=1.
- State register updates at the edge ending the input cycle N. Outputs reflect the new state at the edge ending N+1, a 2-edge latency from input to outputs.
- `speaker` follows `radio_audio`/`alarm_tone` with 1 `clk` of delay.
- `modeSelect` changes appear on outputs after 1 edge.
- A single alarm rings for exactly RING_SECS ticks. Snooze lasts exactly SNOOZE_SECS ticks.
- A match held for multiple cycles triggers once. It re-triggers only after `match_now` falls and rises again.

## Test plan
- Reset with `clock_digits`=`{alarm_time,8'h00}` and `alarm_en`=1 -> no RING; `ringing`=0 and `sndOn`=0 throughout.
- `modeSelect`=1, then 2, in IDLE -> `choice`=`sw_digits` with `sndOn`=0; then `choice`=`clock_digits`, `sndOn`=1, `speaker` tracks `radio_audio` 1 cycle late.
- RING_SECS=4, clock steps 06:59:59 -> 07:00:00 with `alarm_time`=16'h0700:
  - `ringing`=1 two edges later, with `modeSelect`=1 overridden.
  - `blank` toggles on each tick.
  - After the 4th tick, return to IDLE.
- In RING, `btn_stop` and `btn_snooze` in the same cycle -> IDLE, and `snoozing` never asserts.
- SNOOZE_SECS=3: snooze in RING -> `snoozing`=1, `speaker`=0 (mode 0). After 3 ticks -> `ringing`=1 with `ring_cnt` restarted. `btn_snooze` during SNOOZE has no effect.
- `alarm_en` dropped in RING -> IDLE. Snooze pulse coincident with the 4th (timeout) tick -> SNOOZE. `reset` mid-SNOOZE -> all outputs at their reset values next edge.

Source files
------------

// File: rtl/alarm_output_arbiter.sv
// alarm_output_arbiter
//
// Shares the 7-segment digit path and the speaker between the clock,
// stopwatch and radio sources, and runs the alarm scheduler. The alarm
// scheduler detects a match, rings with priority over every display mode,
// and handles stop, snooze and auto-timeout.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | alarm quiet; display and speaker follow modeSelect
// RING   | alarm sounding; clock digits blink once per sec_tick
// SNOOZE | alarm paused; counting sec_ticks until it rings again
//
// Ports
//   clk, reset            system clock, synchronous active-high reset
//   sec_tick              one-clk pulse per second
//   modeSelect            0 clock, 1 stopwatch, 2 radio, 3 same as 0
//   clock_digits          BCD hh:mm:ss
//   sw_digits             BCD stopwatch digits
//   alarm_time            BCD hh:mm
//   alarm_en              alarm armed
//   btn_stop, btn_snooze  debounced one-cycle button pulses
//   radio_audio           radio square wave
//   alarm_tone            alarm square wave
//   choice, blank         digits and blanking to the digit multiplexer
//   speaker, sndOn        audio pin and amplifier enable
//   ringing, snoozing     registered state decodes
module alarm_output_arbiter #(
   parameter int RING_SECS   = 60,
   parameter int SNOOZE_SECS = 300
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        sec_tick,
   input  logic [1:0]  modeSelect,
   input  logic [23:0] clock_digits,
   input  logic [23:0] sw_digits,
   input  logic [15:0] alarm_time,
   input  logic        alarm_en,
   input  logic        btn_stop,
   input  logic        btn_snooze,
   input  logic        radio_audio,
   input  logic        alarm_tone,
   output logic [23:0] choice,
   output logic        blank,
   output logic        speaker,
   output logic        sndOn,
   output logic        ringing,
   output logic        snoozing
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RING   = 2'd1,
      ST_SNOOZE = 2'd2
   } state_t;

   localparam logic [9:0] RING_LAST   = 10'(RING_SECS - 1);
   localparam logic [9:0] SNOOZE_LAST = 10'(SNOOZE_SECS - 1);

   state_t      state_q, state_d;
   logic [9:0]  ring_cnt_q, ring_cnt_d;
   logic [9:0]  snz_cnt_q, snz_cnt_d;
   logic        blink_q, blink_d;
   logic        match_q;
   logic        match_now;
   logic        trigger;

   logic [23:0] choice_q, choice_d;
   logic        blank_q, blank_d;
   logic        speaker_q, speaker_d;
   logic        snd_on_q, snd_on_d;
   logic        ringing_q, snoozing_q;

   assign match_now = alarm_en && (clock_digits[23:8] == alarm_time)
                      && (clock_digits[7:0] == 8'h00);
   // match_q comes out of reset high so a clock already sitting on the
   // alarm time does not look like a fresh rising edge.
   assign trigger   = match_now && !match_q;

   always_comb begin
      state_d    = state_q;
      ring_cnt_d = ring_cnt_q;
      snz_cnt_d  = snz_cnt_q;
      blink_d    = blink_q;
      case (state_q)
         ST_IDLE: begin
            if (trigger) begin
               state_d    = ST_RING;
               ring_cnt_d = 10'd0;
               blink_d    = 1'b0;
            end
         end
         ST_RING: begin
            if (btn_stop) begin
               state_d = ST_IDLE;
            end else if (btn_snooze) begin
               state_d   = ST_SNOOZE;
               snz_cnt_d = 10'd0;
            end else if (!alarm_en) begin
               state_d = ST_IDLE;
            end else if (sec_tick) begin
               if (ring_cnt_q == RING_LAST) begin
                  state_d = ST_IDLE;
               end else begin
                  ring_cnt_d = ring_cnt_q + 10'd1;
                  blink_d    = !blink_q;
               end
            end
         end
         ST_SNOOZE: begin
            if (btn_stop || !alarm_en) begin
               state_d = ST_IDLE;
            end else if (sec_tick) begin
               if (snz_cnt_q == SNOOZE_LAST) begin
                  state_d    = ST_RING;
                  ring_cnt_d = 10'd0;
                  blink_d    = 1'b0;
               end else begin
                  snz_cnt_d = snz_cnt_q + 10'd1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Output selection uses the current (pre-update) state, giving the
   // two-edge input-to-output latency.
   always_comb begin
      choice_d  = clock_digits;
      blank_d   = 1'b0;
      speaker_d = 1'b0;
      snd_on_d  = 1'b0;
      if (state_q == ST_RING) begin
         blank_d   = blink_q;
         speaker_d = alarm_tone;
         snd_on_d  = 1'b1;
      end else begin
         case (modeSelect)
            2'd1: choice_d = sw_digits;
            2'd2: begin
               speaker_d = radio_audio;
               snd_on_d  = 1'b1;
            end
            default: choice_d = clock_digits;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         ring_cnt_q <= 10'd0;
         snz_cnt_q  <= 10'd0;
         blink_q    <= 1'b0;
         match_q    <= 1'b1;
         choice_q   <= 24'h0;
         blank_q    <= 1'b0;
         speaker_q  <= 1'b0;
         snd_on_q   <= 1'b0;
         ringing_q  <= 1'b0;
         snoozing_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         ring_cnt_q <= ring_cnt_d;
         snz_cnt_q  <= snz_cnt_d;
         blink_q    <= blink_d;
         match_q    <= match_now;
         choice_q   <= choice_d;
         blank_q    <= blank_d;
         speaker_q  <= speaker_d;
         snd_on_q   <= snd_on_d;
         ringing_q  <= (state_q == ST_RING);
         snoozing_q <= (state_q == ST_SNOOZE);
      end
   end

   assign choice   = choice_q;
   assign blank    = blank_q;
   assign speaker  = speaker_q;
   assign sndOn    = snd_on_q;
   assign ringing  = ringing_q;
   assign snoozing = snoozing_q;

endmodule

// File: tb/tb_alarm_output_arbiter.sv
module tb_alarm_output_arbiter;

   localparam int RS = 4;
   localparam int SS = 3;

   logic        clk = 1'b0;
   logic        reset;
   logic        sec_tick;
   logic [1:0]  modeSelect;
   logic [23:0] clock_digits;
   logic [23:0] sw_digits;
   logic [15:0] alarm_time;
   logic        alarm_en;
   logic        btn_stop;
   logic        btn_snooze;
   logic        radio_audio;
   logic        alarm_tone;
   logic [23:0] choice;
   logic        blank;
   logic        speaker;
   logic        sndOn;
   logic        ringing;
   logic        snoozing;

   alarm_output_arbiter #(.RING_SECS(RS), .SNOOZE_SECS(SS)) dut (
      .clk(clk), .reset(reset), .sec_tick(sec_tick), .modeSelect(modeSelect),
      .clock_digits(clock_digits), .sw_digits(sw_digits), .alarm_time(alarm_time),
      .alarm_en(alarm_en), .btn_stop(btn_stop), .btn_snooze(btn_snooze),
      .radio_audio(radio_audio), .alarm_tone(alarm_tone), .choice(choice),
      .blank(blank), .speaker(speaker), .sndOn(sndOn), .ringing(ringing),
      .snoozing(snoozing));

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int tsec;                 // time of day in seconds

   // reference model: mode is "idle", "ring" or "snooze"
   string       m_mode;
   int          m_rung;      // ticks rung so far in this ring
   int          m_snoozed;   // ticks spent in this snooze
   bit          m_blank;
   bit          m_prev_match;
   logic [23:0] e_choice;
   logic        e_blank, e_speaker, e_snd, e_ring, e_snz;

   function automatic logic [23:0] bcd(input int s);
      int h, m, x;
      h = s / 3600;
      m = (s / 60) % 60;
      x = s % 60;
      return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(x / 10), 4'(x % 10)};
   endfunction

   task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic cycle();
      bit match;
      clock_digits = bcd(tsec);
      if (reset) begin
         e_choice = 24'h0; e_blank = 0; e_speaker = 0; e_snd = 0; e_ring = 0; e_snz = 0;
         m_mode = "idle"; m_rung = 0; m_snoozed = 0; m_blank = 0; m_prev_match = 1;
      end else begin
         e_ring = (m_mode == "ring");
         e_snz  = (m_mode == "snooze");
         if (m_mode == "ring") begin
            e_choice = clock_digits; e_blank = m_blank; e_speaker = alarm_tone; e_snd = 1;
         end else begin
            e_blank   = 0;
            e_choice  = (modeSelect == 2'd1) ? sw_digits : clock_digits;
            e_snd     = (modeSelect == 2'd2);
            e_speaker = (modeSelect == 2'd2) ? radio_audio : 1'b0;
         end
         match = alarm_en && (clock_digits == {alarm_time, 8'h00});
         if (m_mode == "idle") begin
            if (match && !m_prev_match) begin
               m_mode = "ring"; m_rung = 0; m_blank = 0;
            end
         end else if (m_mode == "ring") begin
            if (btn_stop) m_mode = "idle";
            else if (btn_snooze) begin m_mode = "snooze"; m_snoozed = 0; end
            else if (!alarm_en) m_mode = "idle";
            else if (sec_tick) begin
               m_rung++;
               if (m_rung == RS) m_mode = "idle";
               else m_blank = !m_blank;
            end
         end else begin
            if (btn_stop || !alarm_en) m_mode = "idle";
            else if (sec_tick) begin
               m_snoozed++;
               if (m_snoozed == SS) begin
                  m_mode = "ring"; m_rung = 0; m_blank = 0;
               end
            end
         end
         m_prev_match = match;
      end
      @(posedge clk);
      #1;
      chk("choice", choice, e_choice);
      chk("blank", 24'(blank), 24'(e_blank));
      chk("speaker", 24'(speaker), 24'(e_speaker));
      chk("sndOn", 24'(sndOn), 24'(e_snd));
      chk("ringing", 24'(ringing), 24'(e_ring));
      chk("snoozing", 24'(snoozing), 24'(e_snz));
      if (sec_tick) tsec = (tsec + 1) % 86400;
   endtask

   task automatic step(input bit tick = 0, input bit stop = 0, input bit snz = 0);
      sec_tick    = tick;
      btn_stop    = stop;
      btn_snooze  = snz;
      alarm_tone  = 1'($urandom);
      radio_audio = 1'($urandom);
      sw_digits   = 24'($urandom);
      cycle();
      sec_tick   = 0;
      btn_stop   = 0;
      btn_snooze = 0;
   endtask

   task automatic tick_gap();
      repeat ($urandom_range(1, 3)) step();
      step(1);
   endtask

   task automatic ticks(input int n);
      repeat (n) tick_gap();
   endtask

   // Park the clock one second before hh:mm:00 and tick into the match;
   // ends after the edge where ringing should first be visible.
   task automatic arm(input int hh, input int mm);
      logic [23:0] t;
      t          = bcd(hh * 3600 + mm * 60);
      alarm_time = t[23:8];
      tsec       = hh * 3600 + mm * 60 - 1;
      step();
      step(1);
      step();
      step();
   endtask

   initial begin
      reset = 1; sec_tick = 0; btn_stop = 0; btn_snooze = 0; alarm_en = 1;
      modeSelect = 2'd0; alarm_time = 16'h0700; tsec = 7 * 3600;
      radio_audio = 0; alarm_tone = 0; sw_digits = 24'h0; clock_digits = 24'h0;

      // reset while the clock sits on the alarm time: no ring
      step(); step();
      reset = 0;
      repeat (6) step();
      chk("no_ring_out_of_reset", 24'(ringing), 24'd0);
      chk("no_snd_out_of_reset", 24'(sndOn), 24'd0);

      // display / radio routing in IDLE
      modeSelect = 2'd1; repeat (5) step();
      modeSelect = 2'd2; repeat (8) step();
      chk("radio_snd", 24'(sndOn), 24'd1);

      // full ring to timeout, stopwatch mode overridden
      modeSelect = 2'd1;
      arm(6, 60 - 1 + 1);
      chk("ring_latency", 24'(ringing), 24'd1);
      ticks(RS);
      step(); step();
      chk("timeout_idle", 24'(ringing), 24'd0);

      // stop and snooze together: stop wins
      modeSelect = 2'd0;
      arm(7, 5);
      step(0, 1, 1);
      repeat (3) step();
      chk("stop_beats_snooze", 24'(snoozing), 24'd0);

      // snooze, ignored snooze press, re-ring, full restart of ring count
      arm(7, 10);
      step(0, 0, 1);
      step(); step();
      chk("snoozing", 24'(snoozing), 24'd1);
      chk("snooze_quiet", 24'(speaker), 24'd0);
      tick_gap();
      step(0, 0, 1);
      ticks(SS - 1);
      step(); step();
      chk("re_ring", 24'(ringing), 24'd1);
      ticks(RS - 1);
      step(); step();
      chk("ring_restarted", 24'(ringing), 24'd1);
      tick_gap();
      step(); step();
      chk("re_ring_timeout", 24'(ringing), 24'd0);

      // disable while ringing
      arm(7, 20);
      tick_gap();
      alarm_en = 0;
      step(); step(); step();
      alarm_en = 1;
      chk("disable_idle", 24'(ringing), 24'd0);

      // snooze on the timeout tick, then reset mid-snooze
      arm(7, 30);
      ticks(RS - 1);
      step();
      step(1, 0, 1);
      step(); step();
      chk("snooze_on_timeout", 24'(snoozing), 24'd1);
      tick_gap();
      reset = 1;
      step();
      chk("reset_choice", choice, 24'h0);
      chk("reset_speaker", 24'(speaker), 24'd0);
      reset = 0;
      repeat (3) step();

      // randomized mix of modes, buttons and ticks around alarm events
      for (int r = 0; r < 6; r++) begin
         arm($urandom_range(0, 23), $urandom_range(1, 59));
         for (int i = 0; i < 80; i++) begin
            modeSelect = 2'($urandom);
            alarm_en   = ($urandom_range(0, 49) != 0);
            step($urandom_range(0, 3) == 0, $urandom_range(0, 29) == 0,
                 $urandom_range(0, 9) == 0);
         end
         alarm_en = 1;
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
